// File: rtl/serial_sub4b_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and default width.
package serial_sub4b_pkg;

    // Default operand/result width.
    localparam int unsigned DefaultWidth = 4;

    // FSM state encodings.
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

endpackage : serial_sub4b_pkg

// File: rtl/serial_sub4b_fullsub1b.sv
// One-bit full subtractor cell: d = a - b - br_in, with borrow out.
module serial_sub4b_fullsub1b (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    // Pure combinational difference and borrow.
    always_comb begin
        d      = a ^ b ^ br_in;
        br_out = (~a & b) | (~(a ^ b) & br_in);
    end

endmodule : serial_sub4b_fullsub1b

// File: rtl/serial_sub4b.sv
// Bit-serial unsigned subtractor: diff = a - b - b_in, LSB first over WIDTH cycles,
// with a start/done handshake. One full-subtractor cell plus a borrow flop.
module serial_sub4b
    import serial_sub4b_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;

    logic             bit_d;
    logic             bit_br;

    // The only arithmetic in the datapath: current LSBs plus the running borrow.
    serial_sub4b_fullsub1b u_fullsub (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .br_in  (br_q),
        .d      (bit_d),
        .br_out (bit_br)
    );

    // Next-state logic for the FSM, counter, shift registers and result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = b_in;
                    res_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = bit_br;
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                res_d  = {bit_d, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    b_out_d = bit_br;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
        end
    end

    // Outputs come straight from registers; no input-to-output combinational path.
    always_comb begin
        diff  = diff_q;
        b_out = b_out_q;
        busy  = (state_q == StShift);
        done  = (state_q == StDone);
    end

endmodule : serial_sub4b

// File: tb/tb_serial_sub4b.sv
// Self-checking bench for serial_sub4b with an arithmetic reference model.
module tb_serial_sub4b;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic [W-1:0] diff;
    logic         b_out;
    logic         busy;
    logic         done;

    int errs   = 0;
    int checks = 0;

    // Values diff/b_out are expected to hold between results.
    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;

    serial_sub4b #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .diff  (diff),
        .b_out (b_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Applies one operation (start asserted now, accepted at the next edge) and
    // checks every cycle through the done pulse. Returns #1 after the done edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input bit noisy);
        int           full;
        logic [W-1:0] exp_d;
        logic         exp_b;
        full  = int'(av) - int'(bv) - int'(bi);
        exp_d = full[W-1:0];
        exp_b = (full < 0);

        a = av; b = bv; b_in = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
        for (int k = 1; k <= W; k++) begin
            if (noisy) start = 1'($urandom);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errs++;
                $display("FAIL shift_flags op=%0d-%0d-%0d k=%0d: busy=%b done=%b, want busy=1 done=0",
                         av, bv, bi, k, busy, done);
            end
            checks++;
            if (diff !== last_diff || b_out !== last_bout) begin
                errs++;
                $display("FAIL hold op=%0d-%0d-%0d k=%0d: diff=%b b_out=%b, want diff=%b b_out=%b",
                         av, bv, bi, k, diff, b_out, last_diff, last_bout);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL done_flags op=%0d-%0d-%0d: done=%b busy=%b, want done=1 busy=0",
                     av, bv, bi, done, busy);
        end
        checks++;
        if (diff !== exp_d || b_out !== exp_b) begin
            errs++;
            $display("FAIL result op=%0d-%0d-%0d: diff=%b b_out=%b, want diff=%b b_out=%b",
                     av, bv, bi, diff, b_out, exp_d, exp_b);
        end
        last_diff = exp_d;
        last_bout = exp_b;
    endtask

    // Idle cycles with start low: no done, no busy, results held.
    task automatic idle_cycles(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || diff !== last_diff || b_out !== last_bout) begin
                errs++;
                $display("FAIL idle i=%0d: done=%b busy=%b diff=%b b_out=%b, want 0 0 %b %b",
                         i, done, busy, diff, b_out, last_diff, last_bout);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (diff !== '0 || b_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: diff=%b b_out=%b busy=%b done=%b, want all 0",
                     diff, b_out, busy, done);
        end
        rst_n = 1'b1;
        last_diff = '0;
        last_bout = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_directed();
        run_op(4'd0, 4'd0, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(4'd12, 4'd3, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(4'd12, 4'd3, 1'b1, 1'b0);
        idle_cycles(1);
        run_op(4'd0, 4'd15, 1'b1, 1'b0);
        idle_cycles(1);
        run_op(4'd3, 4'd12, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(4'd15, 4'd15, 1'b1, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        run_op(4'd12, 4'd3, 1'b0, 1'b1);
        // Start held in DONE: accepted on the very next edge.
        run_op(4'd15, 4'd15, 1'b0, 1'b1);
        run_op(4'd7, 4'd9, 1'b1, 1'b1);
        idle_cycles(4);
    endtask

    task automatic test_reset_mid_shift();
        run_op(4'd12, 4'd3, 1'b0, 1'b0);
        a = 4'd5; b = 4'd9; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (diff !== '0 || b_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset: diff=%b b_out=%b busy=%b done=%b, want all 0",
                     diff, b_out, busy, done);
        end
        last_diff = '0;
        last_bout = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(8);
        run_op(4'd9, 4'd4, 1'b1, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_sweep();
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(W'(ia), W'(ib), 1'(ic), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
                end
            end
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_shift();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_serial_sub4b
